// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic int cnt_width(input int db);
        return (db < 1) ? 1 : $clog2(db + 1);
    endfunction

    function automatic logic mode_hit(input edge_mode_e m, input logic rise, input logic fall);
        return (rise && (m == EDGE_RISE || m == EDGE_BOTH)) ||
               (fall && (m == EDGE_FALL || m == EDGE_BOTH));
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One channel: optional synchroniser, stability debounce, registered rise/fall pulses.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic s;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            // Raw input enters at the MSB and reaches bit 0 after SYNC_STAGES edges.
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sync_q <= '0;
                else        sync_q <= SYNC_STAGES'({in_i, sync_q} >> 1);
            end
            assign s = sync_q[0];
        end else begin : g_nosync
            assign s = in_i;
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector with per-channel mode gating,
// sticky event flags and a masked interrupt.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_sig,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   irq_mask,
    input  logic [N_CH-1:0]   flag_clr,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   rise_pulse,
    output logic [N_CH-1:0]   fall_pulse,
    output logic [N_CH-1:0]   evt_pulse,
    output logic [N_CH-1:0]   evt_flag,
    output logic              irq
);

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            edge_det_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_CYCLES   (DB_CYCLES)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .in_i    (in_sig[g]),
                .level_o (level[g]),
                .rise_o  (rise_pulse[g]),
                .fall_o  (fall_pulse[g])
            );
        end
    endgenerate

    // Mode is applied after the pulse registers so a mode change never disturbs debounce state.
    always_comb begin
        evt_pulse = '0;
        for (int i = 0; i < N_CH; i++) begin
            evt_pulse[i] = mode_hit(edge_mode_e'(mode[2*i +: 2]), rise_pulse[i], fall_pulse[i]);
        end
    end

    logic [N_CH-1:0] flag_q, flag_d;

    // A set in the same cycle as a clear wins.
    assign flag_d = (flag_q & ~flag_clr) | evt_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flag_q <= '0;
        else        flag_q <= flag_d;
    end

    assign evt_flag = flag_q;
    assign irq      = |(flag_q & irq_mask);

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: default build plus a SYNC_STAGES=0, DB_CYCLES=1 build.
module tb_multi_edge_detector;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  in_sig, irq_mask, flag_clr;
    logic [15:0] mode;
    logic [7:0]  level, rise_pulse, fall_pulse, evt_pulse, evt_flag;
    logic        irq;

    logic [7:0]  f_in, f_mask, f_clr;
    logic [15:0] f_mode;
    logic [7:0]  f_level, f_rise, f_fall, f_evt, f_flag;
    logic        f_irq;

    multi_edge_detector #(.N_CH(8), .SYNC_STAGES(2), .DB_CYCLES(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sig     (in_sig),
        .mode       (mode),
        .irq_mask   (irq_mask),
        .flag_clr   (flag_clr),
        .level      (level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .evt_pulse  (evt_pulse),
        .evt_flag   (evt_flag),
        .irq        (irq)
    );

    multi_edge_detector #(.N_CH(8), .SYNC_STAGES(0), .DB_CYCLES(1)) u_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sig     (f_in),
        .mode       (f_mode),
        .irq_mask   (f_mask),
        .flag_clr   (f_clr),
        .level      (f_level),
        .rise_pulse (f_rise),
        .fall_pulse (f_fall),
        .evt_pulse  (f_evt),
        .evt_flag   (f_flag),
        .irq        (f_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int nr, nf, ne;
    logic [1:0] mv;

    initial begin
        rst_n    = 1'b0;
        in_sig   = '0;
        irq_mask = '0;
        flag_clr = '0;
        mode     = '0;
        mode[1:0] = 2'b01;
        mode[7:6] = 2'b11;
        mode[9:8] = 2'b01;
        f_in   = '0;
        f_mask = 8'hFF;
        f_clr  = '0;
        f_mode = 16'hFFFF;

        tick();
        tick();
        check("rst_level", level, 8'h00);
        check("rst_rise",  rise_pulse, 8'h00);
        check("rst_fall",  fall_pulse, 8'h00);
        check("rst_flag",  evt_flag, 8'h00);
        check("rst_irq",   irq, 1'b0);
        check("rst_fast_flag", f_flag, 8'h00);
        rst_n = 1'b1;
        tick();

        // Clean rise on ch0: pulse exactly 6 edges after the change.
        irq_mask = 8'h01;
        in_sig[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("t1_rise", rise_pulse[0], (i == 6));
            check("t1_fall", fall_pulse[0], 1'b0);
        end
        check("t1_level", level[0], 1'b1);
        check("t1_flag",  evt_flag[0], 1'b1);
        check("t1_irq",   irq, 1'b1);
        flag_clr[0] = 1'b1;
        tick();
        flag_clr[0] = 1'b0;
        check("t1_clr_flag", evt_flag[0], 1'b0);
        check("t1_clr_irq",  irq, 1'b0);
        irq_mask = '0;

        // Glitch of 3 cycles on ch1 must be ignored and leave the counter at zero.
        in_sig[1] = 1'b1;
        tick(); tick(); tick();
        in_sig[1] = 1'b0;
        nr = 0; nf = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nr += rise_pulse[1];
            nf += fall_pulse[1];
        end
        check("t2_rise_cnt", nr, 0);
        check("t2_fall_cnt", nf, 0);
        check("t2_level", level[1], 1'b0);
        in_sig[1] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t2_restart_rise", rise_pulse[1], (i == 6));
        end
        in_sig[1] = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Mode sweep on ch2.
        for (int m = 0; m < 4; m++) begin
            mv = 2'(m);
            mode[5:4] = mv;
            in_sig[2] = 1'b1;
            nr = 0; ne = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                nr += rise_pulse[2];
                ne += evt_pulse[2];
            end
            check("t3_rise_cnt", nr, 1);
            check("t3_rise_evt", ne, mv[0]);
            check("t3_rise_flag", evt_flag[2], mv[0]);
            flag_clr[2] = 1'b1;
            tick();
            flag_clr[2] = 1'b0;
            in_sig[2] = 1'b0;
            nf = 0; ne = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                nf += fall_pulse[2];
                ne += evt_pulse[2];
            end
            check("t3_fall_cnt", nf, 1);
            check("t3_fall_evt", ne, mv[1]);
            check("t3_fall_flag", evt_flag[2], mv[1]);
            flag_clr[2] = 1'b1;
            tick();
            flag_clr[2] = 1'b0;
        end

        // ch3: clear coinciding with evt_pulse loses to the set.
        in_sig[3] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t4_pre_evt", evt_pulse[3], 1'b0);
        tick();
        check("t4_evt", evt_pulse[3], 1'b1);
        flag_clr[3] = 1'b1;
        tick();
        flag_clr[3] = 1'b0;
        check("t4_set_wins", evt_flag[3], 1'b1);
        irq_mask = 8'h08;
        #1;
        check("t4_irq_on", irq, 1'b1);
        flag_clr[3] = 1'b1;
        tick();
        flag_clr[3] = 1'b0;
        check("t4_clr_flag", evt_flag[3], 1'b0);
        check("t4_irq_off",  irq, 1'b0);
        irq_mask = '0;

        // Settle: only ch0 high, all flags cleared.
        in_sig = 8'h01;
        for (int i = 0; i < 10; i++) tick();
        flag_clr = 8'hFF;
        tick();
        flag_clr = '0;
        check("t5_pre_level", level, 8'h01);
        check("t5_pre_flag",  evt_flag, 8'h00);

        // Reset in the middle of a ch4 debounce (count at 2).
        in_sig = 8'h11;
        for (int i = 0; i < 4; i++) tick();
        check("t5_no_early", rise_pulse, 8'h00);
        rst_n = 1'b0;
        #1;
        check("t5_rst_level", level, 8'h00);
        check("t5_rst_rise",  rise_pulse, 8'h00);
        check("t5_rst_flag",  evt_flag, 8'h00);
        check("t5_rst_irq",   irq, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        nr = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("t5_rise", rise_pulse, (i == 6) ? 8'h11 : 8'h00);
        end
        check("t5_level", level, 8'h11);
        check("t5_flag",  evt_flag, 8'h11);

        // Zero-sync, no-filter build: simultaneous rises on all channels.
        f_in = 8'hFF;
        #1;
        check("t6_rise_before_edge", f_rise, 8'h00);
        tick();
        check("t6_rise", f_rise, 8'hFF);
        check("t6_level", f_level, 8'hFF);
        check("t6_evt", f_evt, 8'hFF);
        tick();
        check("t6_rise_gone", f_rise, 8'h00);
        check("t6_flag", f_flag, 8'hFF);
        check("t6_irq", f_irq, 1'b1);
        f_in = 8'h00;
        tick();
        check("t6_fall", f_fall, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
Multi-channel, parametrised edge detector. Each channel has an optional N-stage synchroniser, a stability debounce filter, and per-channel rise/fall/both mode selection. Outputs are single-cycle pulses, debounced levels, sticky event flags with per-bit clear, and a masked interrupt. It sits between asynchronous board inputs (buttons, sensor strobes) and the control/CSR logic.

Parameters:
- N_CH, 8: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel. 0 means the input is already synchronous and is used directly.
- DB_CYCLES, 4: consecutive cycles the synchronised input must differ from the filtered level before it is accepted (1..65535). 1 means no filtering, one cycle of lag.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_sig  in  N_CH  raw input, one bit per channel
- mode  in  2*N_CH  per-channel edge mode; bits [2i+1:2i] belong to channel i
- irq_mask  in  N_CH  1 = flag bit contributes to irq
- flag_clr  in  N_CH  1-cycle clear strobe per flag bit
- level  out  N_CH  debounced level
- rise_pulse  out  N_CH  1-cycle pulse on accepted 0->1 transition (not gated by mode)
- fall_pulse  out  N_CH  1-cycle pulse on accepted 1->0 transition (not gated by mode)
- evt_pulse  out  N_CH  1-cycle pulse on a transition enabled by mode
- evt_flag  out  N_CH  sticky event flags
- irq  out  1  |(evt_flag & irq_mask)

Behaviour:
- Reset (async assert, sync release): all sync flops, debounce counters, level, rise_pulse, fall_pulse, evt_pulse and evt_flag are 0; irq = 0.
- Mode encoding per channel: 00 OFF, 01 RISE, 10 FALL, 11 BOTH.
- Sync: s = last stage of the SYNC_STAGES shift chain; with 0 stages, s = in_sig.
- Debounce, per channel, with counter cnt of width $clog2(DB_CYCLES+1):
  - If s == level: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: level <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DB_CYCLES cycles never changes level, because the counter restarts on any return to s == level.
- Pulses are registered and assert in the same cycle level changes:
  - rise_pulse = 1 on a 0->1 acceptance, fall_pulse = 1 on a 1->0 acceptance.
  - Both are high for exactly one cycle and are never high together on one channel.
- evt_pulse[i] = (rise_pulse[i] & mode[2i]) | (fall_pulse[i] & mode[2i+1]). It is combinational from registered pulses and current mode.
- Latency from a clean input change (setup met before edge k) to pulse/level: SYNC_STAGES + DB_CYCLES clock edges. For defaults, the pulse is high after edge k+6 (k+3 for S=2, DB=1).
- evt_flag[i]:
  - Set on evt_pulse[i].
  - Cleared by flag_clr[i].
  - If set and clear occur in the same cycle, set wins.
  - Clearing an already-clear flag has no effect.
- irq is combinational from registered flags and irq_mask.
- Mode changes take effect immediately on evt_pulse. They never alter level, pulses or debounce state.
- Input held high through reset release: the channel reports one rise (rise_pulse, plus evt_pulse/flag if enabled) after SYNC_STAGES+DB_CYCLES cycles. This is intended.
- Reset mid-debounce discards the partial count; no pulse is emitted.
- Toggling faster than DB_CYCLES produces no pulses, and level holds its last accepted value.
- Channels are fully independent; simultaneous events on all channels are all captured.

Decomposition:
- Package edge_det_pkg:
  - edge_mode_e enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH, 2-bit).
  - Function cnt_width(db) returning $clog2(db+1).
- Sub-module edge_det_chan holds the single-channel sync chain, debounce counter, level, and rise/fall pulse registers. The top instantiates it N_CH times in a generate loop and adds the mode gating, flag and irq logic.

Test Plan:
- Defaults, ch0 mode=01, in_sig[0] 0->1 held: rise_pulse[0] high for exactly 1 cycle, 6 edges after the change; level[0]=1; evt_flag[0]=1; irq=1 with irq_mask[0]=1.
- Glitch: in_sig[1] high for 3 cycles then low (DB=4) -> no pulses, level[1] stays 0, and the counter returns to 0.
- Mode sweep on ch2 with a full 0->1->0 cycle: OFF gives rise/fall pulses but evt_flag=0; RISE flags the rise only; FALL flags the fall only; BOTH gives two evt_pulses.
- flag_clr[3] asserted in the same cycle as evt_pulse[3] -> evt_flag[3] stays 1; a later clr alone -> 0, and irq drops the next cycle.
- Reset asserted midway through a debounce on ch4 (cnt=2) -> all outputs 0 immediately. After release with in_sig[4]=1, exactly one rise_pulse appears 6 cycles later.
- SYNC_STAGES=0, DB_CYCLES=1 build: an input change before edge k gives a pulse after edge k+1. Simultaneous rises on all N_CH channels all set flags.
